// File: rtl/keypad_scanner_pkg.sv
// Shared constants and key-decode helper for the matrix keypad front end.
// Matrix positions are numbered row*4+col, with row 0 holding keys 1 2 3 A.
package keypad_scanner_pkg;

    localparam int         SNAP_W   = 16;
    localparam int         DIGIT_W  = 10;
    localparam logic [3:0] ROW_IDLE = 4'b1111;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_7    = 4'd8;
    localparam logic [3:0] KEY_8    = 4'd9;
    localparam logic [3:0] KEY_9    = 4'd10;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_0    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    typedef logic [DIGIT_W-1:0] digit_bus_t;

    typedef enum logic [2:0] {
        KIND_NONE,
        KIND_DIGIT,
        KIND_START,
        KIND_STOP,
        KIND_CLEAR
    } key_kind_e;

    typedef struct packed {
        key_kind_e  kind;
        logic [3:0] digit;
    } key_info_t;

    // Star, hash and D are real keys for chord detection but drive nothing.
    function automatic key_info_t decodeKey(input logic [3:0] idx);
        key_info_t k;
        k.kind  = KIND_DIGIT;
        k.digit = 4'd0;
        case (idx)
            KEY_1:    k.digit = 4'd1;
            KEY_2:    k.digit = 4'd2;
            KEY_3:    k.digit = 4'd3;
            KEY_4:    k.digit = 4'd4;
            KEY_5:    k.digit = 4'd5;
            KEY_6:    k.digit = 4'd6;
            KEY_7:    k.digit = 4'd7;
            KEY_8:    k.digit = 4'd8;
            KEY_9:    k.digit = 4'd9;
            KEY_0:    k.digit = 4'd0;
            KEY_A:    k.kind  = KIND_START;
            KEY_B:    k.kind  = KIND_STOP;
            KEY_C:    k.kind  = KIND_CLEAR;
            KEY_STAR, KEY_HASH, KEY_D: k.kind = KIND_NONE;
            default:  k.kind  = KIND_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin side (row drive / column sense) and microwave-core side outputs.
interface keypad_scanner_if;
    import keypad_scanner_pkg::*;

    logic [3:0] col_n;
    logic [3:0] row_n;
    digit_bus_t keypad;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       key_strobe;

    modport master (
        input  col_n,
        output row_n, keypad, startn, stopn, clearn, key_strobe
    );

    modport slave (
        output col_n,
        input  row_n, keypad, startn, stopn, clearn, key_strobe
    );

endinterface

// File: rtl/keypad_debounce.sv
// Accepts a full-matrix snapshot once it has been seen STABLE_SCANS times in a row.
module keypad_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int STABLE_SCANS = 2,
    parameter int WIDTH        = SNAP_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_snap,
    output logic [WIDTH-1:0] o_accepted
);

    localparam int CW = $clog2(STABLE_SCANS + 1);

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_accepted;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_nextCount;

    // Any difference from the previous snapshot restarts the run at one.
    always_comb begin
        w_nextCount = CW'(1);
        if (i_snap == r_prev) begin
            if (r_count >= CW'(STABLE_SCANS)) begin
                w_nextCount = CW'(STABLE_SCANS);
            end else begin
                w_nextCount = r_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_prev     <= '0;
            r_count    <= '0;
            r_accepted <= '0;
        end else if (i_valid) begin
            r_prev  <= i_snap;
            r_count <= w_nextCount;
            if (w_nextCount == CW'(STABLE_SCANS)) begin
                r_accepted <= i_snap;
            end
        end
    end

    assign o_accepted = r_accepted;

endmodule

// File: rtl/keypad_scanner.sv
// Row scanner, column synchronizer, snapshot builder and key decoder for a 4x4 keypad.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int STABLE_SCANS = 2
) (
    input  logic              clock,
    input  logic              resetn,
    keypad_scanner_if.master  bus
);

    localparam int ROW_LAST  = ROWS - 1;
    localparam int SNAP_BITS = ROWS * COLS;

    logic [1:0]                r_rowIdx;
    logic [1:0]                r_rowPipe0;
    logic [1:0]                r_rowPipe1;
    logic [3:0]                r_rowN;
    logic [3:0]                r_colMeta;
    logic [3:0]                r_colSync;
    logic [ROW_LAST*COLS-1:0]  r_snapWork;

    logic                      w_snapValid;
    logic [SNAP_BITS-1:0]      w_snap;
    logic [SNAP_BITS-1:0]      w_accepted;

    logic [4:0]                w_keyCount;
    logic [3:0]                w_idx;
    key_info_t                 w_key;
    logic                      w_valid;

    digit_bus_t                r_keypad;
    logic                      r_startn;
    logic                      r_stopn;
    logic                      r_clearn;
    logic                      r_strobe;
    logic                      r_keyValid;
    logic [3:0]                r_keyIdx;

    // Row index is delayed two cycles so it lines up with the synchronized columns.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rowIdx   <= 2'd0;
            r_rowN     <= {ROW_IDLE[3:1], 1'b0};
            r_rowPipe0 <= 2'(ROW_LAST);
            r_rowPipe1 <= 2'(ROW_LAST - 1);
            r_colMeta  <= COL_IDLE;
            r_colSync  <= COL_IDLE;
            r_snapWork <= '0;
        end else begin
            r_rowIdx   <= (r_rowIdx == 2'(ROW_LAST)) ? 2'd0 : r_rowIdx + 2'd1;
            r_rowN     <= {r_rowN[2:0], r_rowN[3]};
            r_rowPipe0 <= r_rowIdx;
            r_rowPipe1 <= r_rowPipe0;
            r_colMeta  <= bus.col_n;
            r_colSync  <= r_colMeta;
            if (int'(r_rowPipe1) != ROW_LAST) begin
                r_snapWork[int'(r_rowPipe1)*COLS +: COLS] <= ~r_colSync;
            end
        end
    end

    assign w_snapValid = (r_rowPipe1 == 2'(ROW_LAST));
    assign w_snap      = {~r_colSync, r_snapWork};

    keypad_debounce #(
        .STABLE_SCANS (STABLE_SCANS),
        .WIDTH        (SNAP_BITS)
    ) u_debounce (
        .clock      (clock),
        .resetn     (resetn),
        .i_valid    (w_snapValid),
        .i_snap     (w_snap),
        .o_accepted (w_accepted)
    );

    // Only a lone mapped key is reported; empty or chorded states release everything.
    always_comb begin
        w_keyCount = 5'd0;
        w_idx      = 4'd0;
        for (int i = 0; i < SNAP_BITS; i++) begin
            if (w_accepted[i]) begin
                w_keyCount = w_keyCount + 5'd1;
                w_idx      = 4'(i);
            end
        end
        w_key   = decodeKey(w_idx);
        w_valid = (w_keyCount == 5'd1) && (w_key.kind != KIND_NONE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_keypad   <= '0;
            r_startn   <= 1'b1;
            r_stopn    <= 1'b1;
            r_clearn   <= 1'b1;
            r_strobe   <= 1'b0;
            r_keyValid <= 1'b0;
            r_keyIdx   <= 4'd0;
        end else begin
            r_keyValid <= w_valid;
            r_keyIdx   <= w_idx;
            r_strobe   <= w_valid && (!r_keyValid || (r_keyIdx != w_idx));
            r_keypad   <= '0;
            r_startn   <= 1'b1;
            r_stopn    <= 1'b1;
            r_clearn   <= 1'b1;
            if (w_valid) begin
                case (w_key.kind)
                    KIND_DIGIT: r_keypad <= digit_bus_t'(1) << w_key.digit;
                    KIND_START: r_startn <= 1'b0;
                    KIND_STOP:  r_stopn  <= 1'b0;
                    KIND_CLEAR: r_clearn <= 1'b0;
                    default:    r_keypad <= '0;
                endcase
            end
        end
    end

    assign bus.row_n      = r_rowN;
    assign bus.keypad     = r_keypad;
    assign bus.startn     = r_startn;
    assign bus.stopn      = r_stopn;
    assign bus.clearn     = r_clearn;
    assign bus.key_strobe = r_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: models the key matrix and scoreboards settled outputs, strobe counts and latency.
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    typedef struct {
        string      tag;
        logic [9:0] keypad;
        logic [2:0] btn;
        int         strobes;
        bit         mustChange;
    } exp_t;

    logic        clock   = 1'b0;
    logic        resetn  = 1'b0;
    logic [15:0] pressed = '0;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [12:0] lastExp = {10'b0, 3'b111};
    int          obsStrobes;
    int          changeAt;
    exp_t        sbq[$];

    keypad_scanner_if kif();

    keypad_scanner #(
        .ROWS         (4),
        .COLS         (4),
        .STABLE_SCANS (2)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (kif)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] matrixCols(input logic [3:0] rowN, input logic [15:0] keys);
        logic [3:0] cols;
        cols = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rowN[r] && keys[r*4+c]) cols[c] = 1'b0;
            end
        end
        return cols;
    endfunction

    assign kif.col_n = matrixCols(kif.row_n, pressed);

    function automatic logic [2:0] btns();
        return {kif.startn, kif.stopn, kif.clearn};
    endfunction

    task automatic checkOutput();
        exp_t e;
        bit   latOk;
        if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sbq.pop_front();
            vectors++;
            assert (kif.keypad === e.keypad) else begin
                miscompares++;
                $error("[TB] FAIL %s.keypad observed=%b expected=%b", e.tag, kif.keypad, e.keypad);
            end
            vectors++;
            assert (btns() === e.btn) else begin
                miscompares++;
                $error("[TB] FAIL %s.buttons observed=%b expected=%b", e.tag, btns(), e.btn);
            end
            vectors++;
            assert (obsStrobes === e.strobes) else begin
                miscompares++;
                $error("[TB] FAIL %s.strobes observed=%0d expected=%0d", e.tag, obsStrobes, e.strobes);
            end
            latOk = e.mustChange ? (changeAt >= 1 && changeAt <= 15) : (changeAt == -1);
            vectors++;
            assert (latOk === 1'b1) else begin
                miscompares++;
                $error("[TB] FAIL %s.latency observed=%0d expected=%s", e.tag, changeAt,
                       e.mustChange ? "1..15" : "no change");
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [15:0] pat, input logic [9:0] expKp,
                                 input logic [2:0] expBtn, input int expStrobes, input int hold);
        exp_t        e;
        logic [12:0] startObs;
        e.tag        = tag;
        e.keypad     = expKp;
        e.btn        = expBtn;
        e.strobes    = expStrobes;
        e.mustChange = ({expKp, expBtn} != lastExp);
        sbq.push_back(e);
        lastExp    = {expKp, expBtn};
        startObs   = {kif.keypad, btns()};
        pressed    = pat;
        obsStrobes = 0;
        changeAt   = -1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clock);
            if (kif.key_strobe === 1'b1) obsStrobes++;
            if (changeAt < 0 && {kif.keypad, btns()} !== startObs) changeAt = i;
        end
        checkOutput();
    endtask

    task automatic checkResetState(input string tag);
        vectors++;
        assert ({kif.row_n, kif.keypad, btns(), kif.key_strobe} === {4'b1110, 10'b0, 3'b111, 1'b0}) else begin
            miscompares++;
            $error("[TB] FAIL %s observed row=%b kp=%b btn=%b stb=%b expected row=1110 kp=0 btn=111 stb=0",
                   tag, kif.row_n, kif.keypad, btns(), kif.key_strobe);
        end
    endtask

    initial begin
        logic [3:0] expRows [4];
        expRows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        resetn  = 1'b0;
        pressed = 16'hFFFF;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkResetState("reset");

        resetn  = 1'b1;
        pressed = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            assert (kif.row_n === expRows[i]) else begin
                miscompares++;
                $error("[TB] FAIL rowscan%0d observed=%b expected=%b", i, kif.row_n, expRows[i]);
            end
        end
        repeat (12) @(negedge clock);

        applyStimulus("key2",     16'h0002, 10'b0000000100, 3'b111, 1, 20);
        applyStimulus("rel2",     16'h0000, 10'b0,          3'b111, 0, 20);
        applyStimulus("keyA",     16'h0008, 10'b0,          3'b011, 1, 20);
        applyStimulus("relA",     16'h0000, 10'b0,          3'b111, 0, 20);
        applyStimulus("keyB",     16'h0080, 10'b0,          3'b101, 1, 20);
        applyStimulus("relB",     16'h0000, 10'b0,          3'b111, 0, 20);
        applyStimulus("keyC",     16'h0800, 10'b0,          3'b110, 1, 20);
        applyStimulus("relC",     16'h0000, 10'b0,          3'b111, 0, 20);

        applyStimulus("short9",   16'h0400, 10'b0,          3'b111, 0, 3);
        applyStimulus("short9r",  16'h0000, 10'b0,          3'b111, 0, 20);
        for (int b = 0; b < 5; b++) begin
            applyStimulus("bounce9", (b % 2 == 0) ? 16'h0400 : 16'h0000, 10'b0, 3'b111, 0, 4);
        end
        applyStimulus("bounce9r", 16'h0000, 10'b0,          3'b111, 0, 20);

        applyStimulus("chord35",  16'h0024, 10'b0,          3'b111, 0, 20);
        applyStimulus("only3",    16'h0004, 10'b0000001000, 3'b111, 1, 20);
        applyStimulus("rel3",     16'h0000, 10'b0,          3'b111, 0, 20);

        applyStimulus("key0",     16'h2000, 10'b0000000001, 3'b111, 1, 20);
        resetn = 1'b0;
        @(negedge clock);
        checkResetState("midreset");
        resetn  = 1'b1;
        lastExp = {10'b0, 3'b111};
        applyStimulus("key0again", 16'h2000, 10'b0000000001, 3'b111, 1, 20);
        applyStimulus("rel0",     16'h0000, 10'b0,          3'b111, 0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
